serial_word_rx: RTL

Serial-to-parallel input front end for the FIR datapath. It accepts an LSB-first bit stream under a valid/ready handshake, assembles `DATA_WIDTH`-bit samples, and buffers them in a small FIFO. It presents them to the filter core over a parallel valid/ready interface. It is the receiving end of the serial sample link the sample source drives into `top_level`. It also detects and discards framing errors (valid dropping mid-word).

---
 rtl/serial_word_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_word_rx.sv
// Serial-to-parallel sample receiver: LSB-first bit shifter feeding a small word FIFO,
// with framing-error detection when valid drops in the middle of a word.
module serial_word_rx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_en,
  input  logic                                 i_din,
  input  logic                                 i_din_valid,
  output logic                                 o_ready,
  output logic [DATA_WIDTH-1:0]                o_word,
  output logic                                 o_word_valid,
  input  logic                                 i_word_ready,
  output logic                                 o_frame_err,
  output logic [7:0]                           o_err_count,
  output logic [15:0]                          o_word_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  logic                  last_bit, full, pop, ready, accept, push, frame_err_c;
  logic [DATA_WIDTH-1:0] word_in;

  // Handshake decode; only the final bit of a word waits for FIFO space.
  always_comb begin
    last_bit    = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    full        = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    pop         = (fifo_cnt_q != '0) & i_word_ready;
    ready       = i_rst_n & i_en & (!last_bit | !full | pop);
    accept      = i_en & i_din_valid & ready;
    push        = accept & last_bit;
    frame_err_c = (state_q == S_SHIFT) & i_en & !i_din_valid;
    word_in     = {i_din, sr_q[DATA_WIDTH-1:1]};
  end

  // Next-state logic for the shifter FSM, FIFO and counters.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    frame_err_d = frame_err_c;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d      = word_in;
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + BIT_W'(1);
          state_d   = last_bit ? S_IDLE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (frame_err_c) begin
          sr_d      = '0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (accept) begin
          sr_d      = word_in;
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + BIT_W'(1);
          state_d   = last_bit ? S_IDLE : S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = word_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      word_cnt_d      = word_cnt_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (frame_err_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign o_ready      = ready;
  assign o_word       = mem_q[rd_ptr_q];
  assign o_word_valid = (fifo_cnt_q != '0);
  assign o_frame_err  = frame_err_q;
  assign o_err_count  = err_cnt_q;
  assign o_word_count = word_cnt_q;
  assign o_fifo_count = fifo_cnt_q;

endmodule
